// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter sharing one single-outstanding sdram_controller user port; routes read data to its owner.
// Req sampled in IDLE -> gnt/sd_in_valid next cycle; nothing issues while sd_busy, and a lost read times out.
module sdram_port_arbiter #(
    parameter int ADDR_W  = 23,
    parameter int DATA_W  = 32,
    parameter int RR_EN   = 1,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              p0_req,
    input  logic              p0_rw,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_rvalid,

    input  logic              p1_req,
    input  logic              p1_rw,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_rvalid,

    output logic              sd_in_valid,
    output logic              sd_rw,
    output logic [ADDR_W-1:0] sd_addr,
    output logic [DATA_W-1:0] sd_wdata,
    input  logic              sd_busy,
    input  logic [DATA_W-1:0] sd_rdata,
    input  logic              sd_out_valid,

    output logic              err_timeout
);

    localparam int                CNT_W    = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0]  TMO_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [DATA_W-1:0] TMO_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_HOLD,
        S_WR_WAIT,
        S_RD_WAIT
    } state_t;

    state_t             r_state;
    logic               r_last_gnt;
    logic               r_port;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_any_req;
    logic               w_sel;
    logic [DATA_W-1:0]  w_rsp_dat;

    always_comb begin
        w_any_req = p0_req | p1_req;
        if (p0_req && p1_req) begin
            w_sel = (RR_EN != 0) ? ~r_last_gnt : 1'b0;
        end else begin
            w_sel = p1_req;
        end
        w_rsp_dat = sd_out_valid ? sd_rdata : TMO_DATA;
    end

    // sd_rw/sd_addr/sd_wdata double as the latch of the granted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_last_gnt  <= 1'b1;
            r_port      <= 1'b0;
            r_cnt       <= '0;
            p0_gnt      <= 1'b0;
            p0_rdata    <= '0;
            p0_rvalid   <= 1'b0;
            p1_gnt      <= 1'b0;
            p1_rdata    <= '0;
            p1_rvalid   <= 1'b0;
            sd_in_valid <= 1'b0;
            sd_rw       <= 1'b0;
            sd_addr     <= '0;
            sd_wdata    <= '0;
            err_timeout <= 1'b0;
        end else begin
            sd_in_valid <= 1'b0;
            p0_gnt      <= 1'b0;
            p1_gnt      <= 1'b0;
            p0_rvalid   <= 1'b0;
            p1_rvalid   <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!sd_busy && w_any_req) begin
                        r_port      <= w_sel;
                        r_last_gnt  <= w_sel;
                        sd_rw       <= w_sel ? p1_rw    : p0_rw;
                        sd_addr     <= w_sel ? p1_addr  : p0_addr;
                        sd_wdata    <= w_sel ? p1_wdata : p0_wdata;
                        sd_in_valid <= 1'b1;
                        if (w_sel) begin
                            p1_gnt <= 1'b1;
                        end else begin
                            p0_gnt <= 1'b1;
                        end
                        r_state <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_state <= S_HOLD;
                end

                // The controller raises busy one cycle after in_valid; skip that cycle.
                S_HOLD: begin
                    r_cnt   <= '0;
                    r_state <= sd_rw ? S_WR_WAIT : S_RD_WAIT;
                end

                S_WR_WAIT: begin
                    if (!sd_busy) begin
                        r_state <= S_IDLE;
                    end
                end

                S_RD_WAIT: begin
                    if (sd_out_valid || (r_cnt == TMO_LAST)) begin
                        if (!sd_out_valid) begin
                            err_timeout <= 1'b1;
                        end
                        if (r_port) begin
                            p1_rdata  <= w_rsp_dat;
                            p1_rvalid <= 1'b1;
                        end else begin
                            p0_rdata  <= w_rsp_dat;
                            p0_rvalid <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a round-robin and a fixed-priority instance share stimulus.
module tb_sdram_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        p0_req, p0_rw, p1_req, p1_rw;
    logic [22:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        sd_busy, sd_out_valid;
    logic [31:0] sd_rdata;

    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid, sd_in_valid, sd_rw, err_timeout;
    logic [31:0] p0_rdata, p1_rdata, sd_wdata;
    logic [22:0] sd_addr;

    logic        fp_p0_gnt, fp_p0_rvalid, fp_p1_gnt, fp_p1_rvalid, fp_in_valid, fp_rw, fp_err;
    logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_wdata;
    logic [22:0] fp_addr;

    int          n_chk;
    int          n_fail;
    int          rv0_n, rv1_n;
    logic [31:0] rv0_d, rv1_d;

    sdram_port_arbiter #(.ADDR_W(23), .DATA_W(32), .RR_EN(1), .TMO_CYC(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(p0_gnt), .p0_rdata(p0_rdata), .p0_rvalid(p0_rvalid),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(p1_gnt), .p1_rdata(p1_rdata), .p1_rvalid(p1_rvalid),
        .sd_in_valid(sd_in_valid), .sd_rw(sd_rw), .sd_addr(sd_addr), .sd_wdata(sd_wdata),
        .sd_busy(sd_busy), .sd_rdata(sd_rdata), .sd_out_valid(sd_out_valid),
        .err_timeout(err_timeout)
    );

    sdram_port_arbiter #(.ADDR_W(23), .DATA_W(32), .RR_EN(0), .TMO_CYC(255)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_rw(p0_rw), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_gnt(fp_p0_gnt), .p0_rdata(fp_p0_rdata), .p0_rvalid(fp_p0_rvalid),
        .p1_req(p1_req), .p1_rw(p1_rw), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_gnt(fp_p1_gnt), .p1_rdata(fp_p1_rdata), .p1_rvalid(fp_p1_rvalid),
        .sd_in_valid(fp_in_valid), .sd_rw(fp_rw), .sd_addr(fp_addr), .sd_wdata(fp_wdata),
        .sd_busy(sd_busy), .sd_rdata(sd_rdata), .sd_out_valid(sd_out_valid),
        .err_timeout(fp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (p0_rvalid) begin
            rv0_n = rv0_n + 1;
            rv0_d = p0_rdata;
        end
        if (p1_rvalid) begin
            rv1_n = rv1_n + 1;
            rv1_d = p1_rdata;
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic wait_iv(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sd_in_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // Minimal controller: busy for three cycles, then optionally one read response.
    task automatic serve(input logic is_rd, input logic [31:0] d);
        sd_busy = 1'b1;
        repeat (3) @(negedge clk);
        if (is_rd) begin
            sd_rdata     = d;
            sd_out_valid = 1'b1;
            @(negedge clk);
            sd_out_valid = 1'b0;
        end
        sd_busy = 1'b0;
    endtask

    initial begin
        logic ok;
        int   s0, s1, n;

        n_chk = 0; n_fail = 0;
        rv0_n = 0; rv1_n = 0; rv0_d = '0; rv1_d = '0;
        rst_n = 1'b0;
        p0_req = 0; p0_rw = 0; p0_addr = '0; p0_wdata = '0;
        p1_req = 0; p1_rw = 0; p1_addr = '0; p1_wdata = '0;
        sd_busy = 0; sd_out_valid = 0; sd_rdata = '0;

        repeat (2) @(negedge clk);
        chk("rst_gnt", {p0_gnt, p1_gnt}, 2'b00);
        chk("rst_rvalid", {p0_rvalid, p1_rvalid}, 2'b00);
        chk("rst_in_valid", sd_in_valid, 1'b0);
        chk("rst_err", err_timeout, 1'b0);
        chk("rst_sd_addr", sd_addr, 23'h0);
        chk("rst_rdata", {p0_rdata, p1_rdata}, 64'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Test 1: port 0 write
        s0 = rv0_n; s1 = rv1_n;
        p0_req = 1; p0_rw = 1; p0_addr = 23'h000400; p0_wdata = 32'hA5A5_0001;
        @(negedge clk);
        chk("t1_p0_gnt", p0_gnt, 1'b1);
        chk("t1_in_valid", sd_in_valid, 1'b1);
        chk("t1_p1_gnt", p1_gnt, 1'b0);
        chk("t1_sd_rw", sd_rw, 1'b1);
        chk("t1_sd_addr", sd_addr, 23'h000400);
        chk("t1_sd_wdata", sd_wdata, 32'hA5A5_0001);
        p0_req = 0;
        @(negedge clk);
        chk("t1_iv_pulse", {sd_in_valid, p0_gnt}, 2'b00);
        serve(1'b0, 32'h0);
        repeat (4) @(negedge clk);
        chk("t1_no_rv0", rv0_n - s0, 0);
        chk("t1_no_rv1", rv1_n - s1, 0);

        // Test 2: port 1 read
        s0 = rv0_n; s1 = rv1_n;
        p1_req = 1; p1_rw = 0; p1_addr = 23'h000010;
        @(negedge clk);
        chk("t2_p1_gnt", p1_gnt, 1'b1);
        chk("t2_p0_gnt", p0_gnt, 1'b0);
        chk("t2_sd_rw", sd_rw, 1'b0);
        chk("t2_sd_addr", sd_addr, 23'h000010);
        p1_req = 0;
        serve(1'b1, 32'h1234_5678);
        repeat (3) @(negedge clk);
        chk("t2_rv1_cnt", rv1_n - s1, 1);
        chk("t2_rv1_data", rv1_d, 32'h1234_5678);
        chk("t2_rv0_cnt", rv0_n - s0, 0);
        chk("t2_p1_rdata_held", p1_rdata, 32'h1234_5678);

        // Test 3: continuous contention, both instances in lockstep
        s0 = rv0_n; s1 = rv1_n;
        p0_req = 1; p0_rw = 0; p0_addr = 23'h000100;
        p1_req = 1; p1_rw = 0; p1_addr = 23'h000200;
        for (int i = 0; i < 4; i++) begin
            wait_iv(ok);
            chk("t3_iv_seen", ok, 1'b1);
            chk("t3_rr_gnt", {p0_gnt, p1_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk("t3_fp_gnt", {fp_p0_gnt, fp_p1_gnt}, 2'b10);
            serve(1'b1, 32'h3000_0000 + 32'(i));
        end
        p0_req = 0; p1_req = 0;
        repeat (3) @(negedge clk);
        chk("t3_rv0_cnt", rv0_n - s0, 2);
        chk("t3_rv1_cnt", rv1_n - s1, 2);
        chk("t3_rv1_last", rv1_d, 32'h3000_0003);
        chk("t3_fp_p0_rdata", fp_p0_rdata, 32'h3000_0003);

        // Test 4: lost read response -> timeout
        s1 = rv1_n;
        p0_req = 1; p0_rw = 0; p0_addr = 23'h000777;
        wait_iv(ok);
        chk("t4_iv_seen", ok, 1'b1);
        chk("t4_p0_gnt", p0_gnt, 1'b1);
        p0_req = 0;
        sd_busy = 1;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (p0_rvalid) begin
                n = i;
                break;
            end
        end
        chk("t4_tmo_latency", n, 257);
        chk("t4_tmo_data", p0_rdata, 32'hDEAD_BEEF);
        chk("t4_err", err_timeout, 1'b1);
        chk("t4_fp_err", fp_err, 1'b1);
        sd_busy = 0;
        repeat (2) @(negedge clk);
        s0 = rv0_n;
        sd_rdata = 32'h5555_AAAA; sd_out_valid = 1;
        @(negedge clk);
        sd_out_valid = 0;
        repeat (3) @(negedge clk);
        chk("t4_stray_rv0", rv0_n - s0, 0);
        chk("t4_stray_rv1", rv1_n - s1, 0);
        chk("t4_err_sticky", err_timeout, 1'b1);

        // Test 5: no issue while controller busy
        sd_busy = 1;
        p1_req = 1; p1_rw = 1; p1_addr = 23'h000055; p1_wdata = 32'h0BAD_F00D;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sd_in_valid || p0_gnt || p1_gnt) n = n + 1;
        end
        chk("t5_no_issue_busy", n, 0);
        sd_busy = 0;
        @(negedge clk);
        chk("t5_p1_gnt", p1_gnt, 1'b1);
        chk("t5_in_valid", sd_in_valid, 1'b1);
        chk("t5_sd_wdata", sd_wdata, 32'h0BAD_F00D);
        p1_req = 0;
        serve(1'b0, 32'h0);
        repeat (3) @(negedge clk);

        // Test 6: reset in RD_WAIT after a port 0 grant
        p0_req = 1; p0_rw = 0; p0_addr = 23'h000300;
        wait_iv(ok);
        chk("t6_p0_gnt", ok & p0_gnt, 1'b1);
        p0_req = 0;
        sd_busy = 1;
        repeat (5) @(negedge clk);
        rst_n = 0;
        @(negedge clk);
        chk("t6_rst_err", err_timeout, 1'b0);
        chk("t6_rst_rdata", p0_rdata, 32'h0);
        chk("t6_rst_sd", {sd_in_valid, sd_rw, sd_addr}, 25'h0);
        chk("t6_rst_fp_err", fp_err, 1'b0);
        s0 = rv0_n; s1 = rv1_n;
        rst_n = 1;
        @(negedge clk);
        sd_rdata = 32'hCAFE_0001; sd_out_valid = 1;
        @(negedge clk);
        sd_out_valid = 0; sd_busy = 0;
        repeat (3) @(negedge clk);
        chk("t6_no_rv", (rv0_n - s0) + (rv1_n - s1), 0);
        p0_req = 1; p0_rw = 1; p0_addr = 23'h000001;
        p1_req = 1; p1_rw = 1; p1_addr = 23'h000002;
        wait_iv(ok);
        chk("t6_iv_seen", ok, 1'b1);
        chk("t6_first_gnt", {p0_gnt, p1_gnt}, 2'b10);
        chk("t6_fp_first_gnt", {fp_p0_gnt, fp_p1_gnt}, 2'b10);
        p0_req = 0; p1_req = 0;
        serve(1'b0, 32'h0);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
